// File: rtl/des_key_sched_seq.sv
// Sequential DES/TDES round-key generator: streams one PC-2 subkey per accepted cycle,
// stage by stage, in encrypt or decrypt order, from a rotating 56-bit CD register.
module des_key_sched_seq #(
    parameter int unsigned KEYS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 start_decrypt,
    input  logic [64*KEYS-1:0]   key_in,
    output logic                 sk_valid,
    input  logic                 sk_ready,
    output logic [47:0]          sk_data,
    output logic [3:0]           sk_round,
    output logic [1:0]           sk_stage,
    output logic                 sk_stage_dec,
    output logic                 sk_last,
    output logic                 busy
);

    localparam int unsigned KW = 64 * KEYS;

    // Entry i holds the 1-based source bit for output bit i+1.
    localparam logic [335:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [287:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Bit n-1 set where shift S[n] is 2.
    localparam logic [15:0] S_TWO = 16'h7EFC;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0] key_q;
    logic          mode_q;
    logic [55:0]   cd_q;

    logic          accept_c;
    logic          hs_c;
    logic          last_c;
    logic [1:0]    stage_inc_c;
    logic          nxt_dec_c;
    logic [63:0]   nxt_key_c;
    logic [63:0]   first_key_c;
    logic [3:0]    shift_idx_c;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[55-i] = k[6'(7'd64 - 7'(PC1_TAB[(55-i)*6 +: 6]))];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[47-i] = cd[6'(6'd56 - PC2_TAB[(47-i)*6 +: 6])];
        return r;
    endfunction

    // C and D halves rotate independently by one or two places.
    function automatic logic [55:0] rot(input logic [55:0] cd, input logic right, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (!right && two)      return {c[25:0], c[27:26], d[25:0], d[27:26]};
        else if (!right)        return {c[26:0], c[27],    d[26:0], d[27]};
        else if (two)           return {c[1:0],  c[27:2],  d[1:0],  d[27:2]};
        else                    return {c[0],    c[27:1],  d[0],    d[27:1]};
    endfunction

    // Encrypt stages start at C1D1, decrypt stages at C16D16 (= C0D0).
    function automatic logic [55:0] load_cd(input logic [63:0] k, input logic dec);
        return dec ? pc1(k) : rot(pc1(k), 1'b0, 1'b0);
    endfunction

    function automatic logic [63:0] pick_key(input logic [KW-1:0] keys, input logic [1:0] idx);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < int'(KEYS); i++)
            if (idx == 2'(i)) r = keys[64*i +: 64];
        return r;
    endfunction

    assign accept_c    = start_valid && start_ready;
    assign hs_c        = sk_valid && sk_ready;
    assign last_c      = (sk_round == 4'd15) && (sk_stage == 2'(KEYS-1));
    assign sk_last     = sk_valid && last_c;
    assign sk_data     = pc2(cd_q);
    assign stage_inc_c = sk_stage + 2'd1;
    assign nxt_dec_c   = mode_q ^ stage_inc_c[0];
    assign nxt_key_c   = pick_key(key_q, mode_q ? 2'(KEYS-1) - stage_inc_c : stage_inc_c);
    assign first_key_c = pick_key(key_in, start_decrypt ? 2'(KEYS-1) : 2'd0);
    assign shift_idx_c = sk_stage_dec ? 4'd15 - sk_round : sk_round + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = RUN;
            RUN:     if (hs_c && last_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        start_ready = 1'b0;
        sk_valid    = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE:    start_ready = 1'b1;
            RUN: begin
                sk_valid = 1'b1;
                busy     = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Key latch, CD rotation and round/stage counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q        <= '0;
            mode_q       <= 1'b0;
            cd_q         <= '0;
            sk_round     <= '0;
            sk_stage     <= '0;
            sk_stage_dec <= 1'b0;
        end else if (accept_c) begin
            key_q        <= key_in;
            mode_q       <= start_decrypt;
            cd_q         <= load_cd(first_key_c, start_decrypt);
            sk_round     <= '0;
            sk_stage     <= '0;
            sk_stage_dec <= start_decrypt;
        end else if (hs_c) begin
            if (sk_round != 4'd15) begin
                cd_q     <= rot(cd_q, sk_stage_dec, S_TWO[shift_idx_c]);
                sk_round <= sk_round + 4'd1;
            end else if (last_c) begin
                sk_round <= '0;
                sk_stage <= '0;
            end else begin
                cd_q         <= load_cd(nxt_key_c, nxt_dec_c);
                sk_round     <= '0;
                sk_stage     <= stage_inc_c;
                sk_stage_dec <= nxt_dec_c;
            end
        end
    end

endmodule
